axi_sync_ctrl: RTL
==================

# axi_sync_ctrl

Packet-aware release controller for a group of AXI-stream lanes that must advance in lockstep. It sits behind the per-lane input FIFOs and releases one beat on every lane in the same cycle. It also checks that all lanes agree on packet boundaries (tlast). On a boundary mismatch it discards each lane up to its own packet end and restarts aligned. It counts alignment errors and flags lanes that stall the group.

## Interface
Parameters:
- SIZE, 2: number of lanes (≥2).
- WIDTH, 32: tdata width per lane; all lanes are equal width.
- TIMEOUT, 1024: partial-valid cycles before `stall` asserts; 0 disables the stall detector.
- ERR_W, 16: width of `err_count`.

Ports:
- clk, in, 1: clock. One clock domain.
- reset, in, 1: synchronous, active-high.
- clear, in, 1: synchronous, active-high soft reset. Identical effect to `reset`.
- i_tdata, in, SIZE*WIDTH: lane k occupies bits [WIDTH*(k+1)-1 : WIDTH*k].
- i_tlast, in, SIZE: per-lane tlast.
- i_tvalid, in, SIZE: per-lane tvalid.
- i_tready, out, SIZE: per-lane tready.
- o_tdata, out, SIZE*WIDTH: same lane packing as `i_tdata`.
- o_tlast, out, SIZE: per-lane tlast.
- o_tvalid, out, SIZE: per-lane tvalid.
- o_tready, in, SIZE: per-lane tready.
- err_count, out, ERR_W: saturating count of completed resyncs.
- stall, out, 1: partial-valid timeout reached.
- resyncing, out, 1: high while in state RESYNC.

## Operation
- Datapath is combinational pass-through: o_tdata = i_tdata, o_tlast = i_tlast.
- Derived terms:
  - all_v = &i_tvalid
  - all_r = &o_tready
  - aligned = (&i_tlast) | ~(|i_tlast)
- State SYNC:
  - fire = all_v & all_r & aligned.
  - o_tvalid = {SIZE{all_v & aligned}}, independent of o_tready per lane. Downstream acceptance is still gated by fire.
  - i_tready = {SIZE{fire}}.
  - If all_v & ~aligned (regardless of o_tready): o_tvalid = 0, i_tready = 0. Next state RESYNC, done = 0.
- State RESYNC: drains each lane to its own packet end.
  - o_tvalid = 0.
  - i_tready[k] = ~done[k].
  - An i_tvalid[k] & i_tready[k] beat is discarded. If it carries i_tlast[k], set done[k].
  - When every done bit is set, including bits set in the current cycle: next state SYNC, done cleared, err_count incremented (saturating at all-ones).
- The mismatching beat itself is consumed in RESYNC. Lanes whose mismatching beat has tlast = 1 complete in the first RESYNC cycle.
- Stall detector (SYNC only):
  - cnt increments while (|i_tvalid) & ~all_v.
  - cnt resets to 0 otherwise, or in RESYNC.
  - cnt saturates at TIMEOUT.
  - stall = (TIMEOUT != 0) & (cnt == TIMEOUT). It deasserts the cycle after the condition ends.
- reset/clear:
  - state → SYNC, done → 0, cnt → 0, err_count → 0.
  - While either is asserted, o_tvalid = 0 and i_tready = 0.
  - Asserting either mid-RESYNC abandons the drain. No err_count increment occurs for that resync.

## Timing
- Latency 0 cycles in SYNC. A beat is presented and accepted in the same cycle as fire.
- SYNC→RESYNC takes effect on the clock edge after mismatch detection. There is no transfer in the detection cycle.
- Minimum RESYNC duration is 1 cycle, when every lane holds a tlast beat.
- First aligned transfer can occur the cycle after RESYNC exits.
- Reset values:
  - o_tvalid = 0, i_tready = 0
  - err_count = 0, stall = 0, resyncing = 0
- o_tdata and o_tlast follow the inputs.
- Simultaneous events:
  - clear wins over all transitions.
  - A RESYNC exit and a saturated err_count leave err_count unchanged.

## Structure
- Shared package `axi_sync_pkg` holds:
  - state encoding: SYNC = 1'b0, RESYNC = 1'b1
  - the default ERR_W
- One sub-module is natural: `axi_sync_stall_timer`.
  - Inputs: clk, reset, enable, cond.
  - Parameter: TIMEOUT.
  - Output: stall.
  - Reused by other sync blocks.

## Test plan
All scenarios use SIZE = 2, WIDTH = 16, TIMEOUT = 8.
1. Aligned 4-beat packets on both lanes, o_tready = 2'b11 → 4 transfers in 4 cycles, lane data matches, err_count = 0.
2. Lane 0 packet of 3 beats, lane 1 packet of 5 beats → third beat is not output. Lane 0 drops 1 beat, lane 1 drops 3 beats. err_count = 1. The next aligned packet passes intact.
3. Both valid and aligned, o_tready = 2'b01 → o_tvalid = 2'b11, i_tready = 0, no data lost. Raising o_tready to 2'b11 transfers the beat.
4. Lane 0 valid, lane 1 idle for 10 cycles → stall rises after 8 cycles. It falls the cycle after lane 1 becomes valid.
5. clear pulsed mid-RESYNC (lane 1 not yet done) → state SYNC, err_count = 0, no output beats. Outputs are 0 during the clear cycle.
6. Force err_count to its limit of 65535 with back-to-back mismatches → it holds 65535 and does not wrap.

Source files
------------

// File: rtl/axi_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_sync_pkg
// Description : Shared types and defaults for the lockstep AXI-stream
//               release controller and related sync blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_sync_pkg;

    // Controller state: SYNC releases aligned beats, RESYNC drains to packet ends
    typedef enum logic [0:0] {
        SYNC   = 1'b0,
        RESYNC = 1'b1
    } sync_state_t;

    // Default width of the resync error counter
    localparam int c_err_w_default = 16;

endpackage
`default_nettype wire

// File: rtl/axi_sync_stall_timer.sv
`default_nettype none
// ============================================================================
// Module      : axi_sync_stall_timer
// Description : Saturating cycle counter that flags a condition held for
//               TIMEOUT consecutive enabled cycles. TIMEOUT = 0 disables it.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_sync_stall_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic cond,
    output logic stall
);

    // Counter must be able to hold TIMEOUT itself; keep at least one bit
    localparam int c_cnt_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT);

    logic [c_cnt_w-1:0] r_cnt;

    // Count consecutive cycles of the condition, saturating at the limit
    always_ff @(posedge clk) begin
        if (reset || !enable || !cond) begin
            r_cnt <= '0;
        end else if (r_cnt != c_limit) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign stall = (TIMEOUT != 0) && (r_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/axi_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : axi_sync_ctrl
// Description : Releases one beat on every lane in the same cycle, checks
//               that all lanes agree on packet boundaries, drains each lane
//               to its own packet end on disagreement, counts resyncs and
//               flags lanes that stall the group.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_sync_ctrl
    import axi_sync_pkg::*;
#(
    parameter int SIZE    = 2,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1024,
    parameter int ERR_W   = c_err_w_default
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [SIZE*WIDTH-1:0] i_tdata,
    input  logic [SIZE-1:0]       i_tlast,
    input  logic [SIZE-1:0]       i_tvalid,
    output logic [SIZE-1:0]       i_tready,
    output logic [SIZE*WIDTH-1:0] o_tdata,
    output logic [SIZE-1:0]       o_tlast,
    output logic [SIZE-1:0]       o_tvalid,
    input  logic [SIZE-1:0]       o_tready,
    output logic [ERR_W-1:0]      err_count,
    output logic                  stall,
    output logic                  resyncing
);

    sync_state_t      r_state;
    logic [SIZE-1:0]  r_done;
    logic [ERR_W-1:0] r_err_count;

    logic             w_rst;
    logic             w_all_v;
    logic             w_all_r;
    logic             w_aligned;
    logic             w_sync;
    logic             w_fire;
    logic             w_mismatch;
    logic             w_stall_cond;
    logic [SIZE-1:0]  w_done_next;

    // clear behaves exactly like reset
    assign w_rst        = reset | clear;
    assign w_all_v      = &i_tvalid;
    assign w_all_r      = &o_tready;
    assign w_aligned    = (&i_tlast) | ~(|i_tlast);
    assign w_sync       = (r_state == SYNC);
    assign w_fire       = w_sync & w_all_v & w_all_r & w_aligned;
    assign w_mismatch   = w_all_v & ~w_aligned;
    assign w_stall_cond = (|i_tvalid) & ~w_all_v;

    // A lane finishes its drain when it discards a tlast beat; bits set this
    // cycle count toward the exit decision
    assign w_done_next  = r_done | (i_tvalid & ~r_done & i_tlast);

    // Datapath is a straight pass-through; only the handshakes are controlled
    assign o_tdata   = i_tdata;
    assign o_tlast   = i_tlast;
    assign err_count = r_err_count;
    assign resyncing = (r_state == RESYNC);

    // Handshake generation: lockstep release in SYNC, per-lane drain in RESYNC
    always_comb begin
        o_tvalid = '0;
        i_tready = '0;
        if (!w_rst) begin
            if (w_sync) begin
                o_tvalid = {SIZE{w_all_v & w_aligned}};
                i_tready = {SIZE{w_fire}};
            end else begin
                i_tready = ~r_done;
            end
        end
    end

    // Control FSM: enter RESYNC on boundary disagreement, leave once every lane drained
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state     <= SYNC;
            r_done      <= '0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                SYNC: begin
                    if (w_mismatch) begin
                        r_state <= RESYNC;
                        r_done  <= '0;
                    end
                end
                RESYNC: begin
                    if (&w_done_next) begin
                        r_state <= SYNC;
                        r_done  <= '0;
                        if (r_err_count != {ERR_W{1'b1}}) begin
                            r_err_count <= r_err_count + ERR_W'(1);
                        end
                    end else begin
                        r_done <= w_done_next;
                    end
                end
                default: begin
                    r_state <= SYNC;
                    r_done  <= '0;
                end
            endcase
        end
    end

    // Partial-valid watchdog, active only while releasing aligned beats
    axi_sync_stall_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_stall_timer (
        .clk    (clk),
        .reset  (w_rst),
        .enable (w_sync),
        .cond   (w_stall_cond),
        .stall  (stall)
    );

endmodule
`default_nettype wire
